lfsr_checker: RTL and testbench

Serial receive-side checker for the 26-bit PRBS produced by the team's LFSR generator (polynomial taps 26, 8, 7, 1). It consumes one generator bit per qualified clock, self-synchronises by loading received bits into a local history register, and predicts each following bit. Once locked it flags and counts bit errors. It declares loss of lock when errors become dense, then re-hunts. It sits at the far end of a PRBS link or loopback path as the BER/link-integrity monitor.

---
 rtl/lfsr_checker_if.sv | 21 ++
 rtl/lfsr_checker.sv | 137 +++++++++++++
 tb/tb_lfsr_checker.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
// Receive-side bus of the PRBS-26 checker: serial input qualifiers and the
// lock/error status returned by the checker.
interface lfsr_checker_if;
   logic        en;
   logic        din;
   logic        clr_cnt;
   logic        locked;
   logic        err;
   logic        lock_lost;
   logic [15:0] err_cnt;

   modport master (
      output en, din, clr_cnt,
      input  locked, err, lock_lost, err_cnt
   );

   modport slave (
      input  en, din, clr_cnt,
      output locked, err, lock_lost, err_cnt
   );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the PRBS-26 stream (taps 26, 8, 7, 1).
// Define LFSR_CHK_ERRCNT_EN to build the saturating err_cnt and clr_cnt logic.
//
// state  | meaning
// HUNT   | loading 26 received bits into the history register
// SYNC   | predicting from received bits, counting consecutive matches
// LOCKED | flywheel on predicted bits, counting errors per window
module lfsr_checker #(
   parameter int LOCK_CNT = 32,
   parameter int WINDOW   = 64,
   parameter int LOSS_ERR = 8
) (
   input logic           clk,
   input logic           rst_n,
   lfsr_checker_if.slave bus
);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   localparam logic [9:0]  LOCK_V = 10'(LOCK_CNT);
   localparam logic [10:0] WIN_V  = 11'(WINDOW);
   localparam logic [10:0] LOSS_V = 11'(LOSS_ERR);

   state_t      state;
   logic [26:1] h;
   logic [4:0]  fill_cnt;
   logic [9:0]  good_cnt;
   logic [10:0] win_cnt;
   logic [10:0] win_err;
   logic        locked;
   logic        err;
   logic        lock_lost;

   logic        pred;
   logic        mismatch;
   logic [26:1] h_din;
   logic [26:1] h_pred;
   logic [9:0]  good_inc;
   logic [10:0] win_inc;
   logic [10:0] win_err_inc;

   assign pred        = h[26] ^ h[8] ^ h[7] ^ h[1];
   assign mismatch    = bus.din ^ pred;
   assign h_din       = {h[25:1], bus.din};
   assign h_pred      = {h[25:1], pred};
   assign good_inc    = good_cnt + 10'd1;
   assign win_inc     = win_cnt + 11'd1;
   assign win_err_inc = win_err + 11'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= HUNT;
         h         <= '0;
         fill_cnt  <= '0;
         good_cnt  <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         err       <= 1'b0;
         lock_lost <= 1'b0;
         if (bus.en) begin
            case (state)
               HUNT: begin
                  h        <= h_din;
                  fill_cnt <= fill_cnt + 5'd1;
                  if (fill_cnt == 5'd25) begin
                     state    <= SYNC;
                     good_cnt <= '0;
                  end
               end
               SYNC: begin
                  h <= h_din;
                  // an all-zero history would predict zeros forever, so a dead line never locks
                  if (mismatch || h_din == '0) begin
                     good_cnt <= '0;
                  end else if (good_inc == LOCK_V) begin
                     good_cnt <= good_inc;
                     state    <= LOCKED;
                     locked   <= 1'b1;
                     win_cnt  <= '0;
                     win_err  <= '0;
                  end else begin
                     good_cnt <= good_inc;
                  end
               end
               LOCKED: begin
                  h <= h_pred;
                  if (mismatch) err <= 1'b1;
                  if (mismatch && win_err_inc == LOSS_V) begin
                     state     <= HUNT;
                     locked    <= 1'b0;
                     lock_lost <= 1'b1;
                     fill_cnt  <= '0;
                     win_cnt   <= '0;
                     win_err   <= '0;
                  end else if (win_inc == WIN_V) begin
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     win_cnt <= win_inc;
                     if (mismatch) win_err <= win_err_inc;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

   assign bus.locked    = locked;
   assign bus.err       = err;
   assign bus.lock_lost = lock_lost;

`ifdef LFSR_CHK_ERRCNT_EN
   logic [15:0] err_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (bus.clr_cnt) begin
         err_cnt <= '0;
      end else if (bus.en && state == LOCKED && mismatch && err_cnt != 16'hFFFF) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end

   assign bus.err_cnt = err_cnt;
`else
   logic unused_clr_cnt;
   assign unused_clr_cnt = bus.clr_cnt;
   assign bus.err_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: default-parameter instance for lock/error/loss
// sequences, plus a wide-window instance that drives err_cnt into saturation.
module tb_lfsr_checker;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   lfsr_checker_if bus ();
   lfsr_checker_if sat_bus ();

   lfsr_checker u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   lfsr_checker #(.LOCK_CNT(32), .WINDOW(1024), .LOSS_ERR(1024)) u_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sat_bus)
   );

   typedef struct {
      logic        err;
      logic        lost;
      logic        locked;
      logic [15:0] cnt;
   } exp_t;

   typedef struct {
      bit en;
      bit inv;
      bit clr;
      bit x_err;
      bit x_lost;
      bit x_locked;
   } vec_t;

   localparam logic [26:1] SEED = 26'h0000001;

   exp_t        sb_q[$];
   vec_t        vecs[8];
   logic [26:1] gq;
   logic [26:1] gs;
   logic [15:0] exp_cnt;
   int          checks   = 0;
   int          failures = 0;
   int          since;

   function automatic logic gen_next();
      logic nb;
      nb = gq[26] ^ gq[8] ^ gq[7] ^ gq[1];
      gq = {gq[25:1], nb};
      return nb;
   endfunction

   function automatic logic gen_sat();
      logic nb;
      nb = gs[26] ^ gs[8] ^ gs[7] ^ gs[1];
      gs = {gs[25:1], nb};
      return nb;
   endfunction

   task automatic check(input string tag, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
      end
   endtask

   task automatic drive(input string tag, input bit e, input bit inv, input bit zero,
                        input bit clr, input bit x_err, input bit x_lost, input bit x_locked);
      exp_t x;
      bus.en      = e;
      bus.clr_cnt = clr;
      if (e) bus.din = zero ? 1'b0 : (gen_next() ^ inv);
      else   bus.din = 1'($urandom);
      if (clr) exp_cnt = 16'h0;
      else if (x_err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      x.err    = x_err;
      x.lost   = x_lost;
      x.locked = x_locked;
`ifdef LFSR_CHK_ERRCNT_EN
      x.cnt    = exp_cnt;
`else
      x.cnt    = 16'h0;
`endif
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      check(tag, "err", 32'(bus.err), 32'(x.err));
      check(tag, "lock_lost", 32'(bus.lock_lost), 32'(x.lost));
      check(tag, "locked", 32'(bus.locked), 32'(x.locked));
      check(tag, "err_cnt", 32'(bus.err_cnt), 32'(x.cnt));
   endtask

   task automatic reset_pulse();
      rst_n       = 1'b0;
      bus.en      = 1'b1;
      bus.din     = 1'($urandom);
      bus.clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      check("reset", "locked", 32'(bus.locked), 32'h0);
      check("reset", "err", 32'(bus.err), 32'h0);
      check("reset", "lock_lost", 32'(bus.lock_lost), 32'h0);
      check("reset", "err_cnt", 32'(bus.err_cnt), 32'h0);
      rst_n       = 1'b1;
      bus.clr_cnt = 1'b0;
      exp_cnt     = 16'h0;
      gq          = SEED;
   endtask

   task automatic drive_sat(input bit inv);
      sat_bus.en  = 1'b1;
      sat_bus.din = gen_sat() ^ inv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nerr;
      vecs[0] = '{1, 1, 1, 1, 0, 1};
      vecs[1] = '{0, 1, 0, 0, 0, 1};
      vecs[2] = '{0, 0, 0, 0, 0, 1};
      vecs[3] = '{1, 0, 0, 0, 0, 1};
      vecs[4] = '{1, 1, 0, 1, 0, 1};
      vecs[5] = '{0, 1, 0, 0, 0, 1};
      vecs[6] = '{1, 1, 0, 1, 0, 1};
      vecs[7] = '{1, 0, 1, 0, 0, 1};

      rst_n           = 1'b0;
      bus.en          = 1'b0;
      bus.din         = 1'b0;
      bus.clr_cnt     = 1'b0;
      sat_bus.en      = 1'b0;
      sat_bus.din     = 1'b0;
      sat_bus.clr_cnt = 1'b0;
      exp_cnt         = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      reset_pulse();

      // clean stream: lock on valid bit 58, then no errors
      for (int i = 1; i <= 10000; i++) drive("clean", 1, 0, 0, 0, 0, 0, i >= 58);
      since = 10000 - 58;

      // single error, then flywheel keeps the next bit clean
      drive("single", 1, 1, 0, 0, 1, 0, 1);
      drive("single_next", 1, 0, 0, 0, 0, 0, 1);
      since += 2;
      while (since % 64 != 0) begin
         drive("align", 1, 0, 0, 0, 0, 0, 1);
         since++;
      end

      // eight errors in one window: loss on the eighth, then re-lock
      for (int k = 1; k <= 8; k++) drive("burst8", 1, 1, 0, 0, 1, k == 8, k != 8);
      for (int i = 1; i <= 58; i++) drive("relock1", 1, 0, 0, 0, 0, 0, i == 58);
      since = 0;

      // seven errors ending on a window close are cleared; next window starts at 1
      while (since % 64 != 57) begin drive("pre7", 1, 0, 0, 0, 0, 0, 1); since++; end
      for (int k = 1; k <= 7; k++) begin drive("tail7", 1, 1, 0, 0, 1, 0, 1); since++; end
      drive("win_head", 1, 1, 0, 0, 1, 0, 1);
      since++;
      // seven more in the same window: the eighth error lands on the closing bit
      while (since % 64 != 57) begin drive("pre7b", 1, 0, 0, 0, 0, 0, 1); since++; end
      for (int k = 1; k <= 7; k++) drive("close_loss", 1, 1, 0, 0, 1, k == 7, k != 7);
      for (int i = 1; i <= 58; i++) drive("relock2", 1, 0, 0, 0, 0, 0, i == 58);

      // clr_cnt priority and en=0 behaviour while locked
      foreach (vecs[i])
         drive($sformatf("vec%0d", i), vecs[i].en, vecs[i].inv, 0, vecs[i].clr,
               vecs[i].x_err, vecs[i].x_lost, vecs[i].x_locked);

      // mid-operation reset from LOCKED
      reset_pulse();

      // dead line never locks
      for (int i = 1; i <= 500; i++) drive("zero_line", 1, 0, 1, 0, 0, 0, 0);

      // en toggling: lock after 58 valid bits, err pulse is one cycle
      reset_pulse();
      for (int v = 1; v <= 58; v++) begin
         drive("toggle_v", 1, 0, 0, 0, 0, 0, v == 58);
         drive("toggle_i", 0, 0, 0, 0, 0, 0, v == 58);
      end
      drive("toggle_err", 1, 1, 0, 0, 1, 0, 1);
      drive("toggle_idle", 0, 0, 0, 0, 0, 0, 1);
      bus.en = 1'b0;

      // saturation on the wide-window instance
      gs = SEED;
      for (int i = 1; i <= 58; i++) drive_sat(1'b0);
      check("sat", "locked_at_58", 32'(sat_bus.locked), 32'h1);
      nerr = 0;
      since = 0;
      while (nerr < 65600) begin
         since++;
         drive_sat(since % 1024 != 0);
         if (since % 1024 != 0) begin
            nerr++;
            if (nerr == 65534)
`ifdef LFSR_CHK_ERRCNT_EN
               check("sat", "err_cnt_65534", 32'(sat_bus.err_cnt), 32'd65534);
`else
               check("sat", "err_cnt_65534", 32'(sat_bus.err_cnt), 32'd0);
`endif
         end
      end
`ifdef LFSR_CHK_ERRCNT_EN
      check("sat", "err_cnt_final", 32'(sat_bus.err_cnt), 32'hFFFF);
`else
      check("sat", "err_cnt_final", 32'(sat_bus.err_cnt), 32'h0);
`endif
      check("sat", "err_last", 32'(sat_bus.err), 32'h1);
      check("sat", "locked_final", 32'(sat_bus.locked), 32'h1);
      check("sat", "lost_final", 32'(sat_bus.lock_lost), 32'h0);
      sat_bus.en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
